// File: rtl/instruction_fetch_unit.sv
// Program counter and fetch stage: drives program_memory, buffers one word
// and hands it downstream over valid/ready, with redirect and end detection.
module instruction_fetch_unit #(
  parameter int unsigned BITS_FOR_INSTRUCTIONS  = 5,
  parameter int unsigned INSTRUCTION_WIDTH      = 16,
  parameter int unsigned NUMBER_OF_INSTRUCTIONS = 32,
  parameter int unsigned LAST_ADDRESS = NUMBER_OF_INSTRUCTIONS - 1,
  parameter bit          WRAP_AROUND            = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             redirect_valid,
  input  logic [BITS_FOR_INSTRUCTIONS-1:0] redirect_address,
  output logic [BITS_FOR_INSTRUCTIONS-1:0] instruction_address,
  input  logic [INSTRUCTION_WIDTH-1:0]     instruction,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [INSTRUCTION_WIDTH-1:0]     out_instruction,
  output logic [BITS_FOR_INSTRUCTIONS-1:0] out_pc,
  output logic                             busy,
  output logic                             done,
  output logic [15:0]                      instr_count
);

  localparam int unsigned B = BITS_FOR_INSTRUCTIONS;
  localparam int unsigned W = INSTRUCTION_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [W-1:0] NOP    = W'(4'hF);
  localparam logic [B-1:0] PC_ONE = B'(1);

  logic [1:0]   state;
  logic [B-1:0] pc;
  logic         slot_free;
  logic         fetch;
  logic         handshake;
  logic         at_last;
  logic         next_oob;
  logic         redir_oob;

  assign instruction_address = pc;
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE) && !out_valid;
  assign handshake = out_valid && out_ready;
  assign slot_free = !out_valid || out_ready;
  assign fetch     = busy && slot_free && !redirect_valid;
  assign at_last   = (32'(pc) == LAST_ADDRESS);
  assign next_oob  = (32'(pc) + 32'd1 >= NUMBER_OF_INSTRUCTIONS);
  assign redir_oob =
    (32'(redirect_address) >= NUMBER_OF_INSTRUCTIONS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      pc              <= '0;
      out_valid       <= 1'b0;
      out_instruction <= NOP;
      out_pc          <= '0;
      instr_count     <= '0;
    end else begin
      // A handshake on a redirect cycle still counts as consumed.
      if (handshake && instr_count != 16'hFFFF)
        instr_count <= instr_count + 16'd1;

      if (redirect_valid) begin
        pc        <= redir_oob ? '0 : redirect_address;
        out_valid <= 1'b0;
        state     <= S_RUN;
      end else begin
        unique case (state)
          S_IDLE:  if (start) state <= S_RUN;
          S_RUN:   ;
          S_DONE:  ;
          default: state <= S_IDLE;
        endcase

        if (fetch) begin
          out_instruction <= instruction;
          out_pc          <= pc;
          out_valid       <= 1'b1;
          if (at_last) begin
            if (WRAP_AROUND) pc    <= '0;
            else             state <= S_DONE;
          end else if (next_oob) begin
            pc <= '0;
          end else begin
            pc <= pc + PC_ONE;
          end
        end else if (handshake) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: stop-at-end and wrapping
// instances, memory model returns the address as the instruction word.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Stop-at-end instance
  logic        rst, start, redir, ready;
  logic [4:0]  redir_addr, iaddr, opc;
  logic [15:0] instr, oinstr, cnt;
  logic        ovalid, busy, done;

  assign instr = {11'd0, iaddr};

  instruction_fetch_unit u_dut (
    .clk(clk), .rst(rst), .start(start),
    .redirect_valid(redir), .redirect_address(redir_addr),
    .instruction_address(iaddr), .instruction(instr),
    .out_valid(ovalid), .out_ready(ready),
    .out_instruction(oinstr), .out_pc(opc),
    .busy(busy), .done(done), .instr_count(cnt)
  );

  // Wrapping instance
  logic        w_rst, w_start, w_redir, w_ready;
  logic [4:0]  w_redir_addr, w_iaddr, w_opc;
  logic [15:0] w_instr, w_oinstr, w_cnt;
  logic        w_ovalid, w_busy, w_done;

  assign w_instr = {11'd0, w_iaddr};

  instruction_fetch_unit #(.WRAP_AROUND(1'b1)) u_wrap (
    .clk(clk), .rst(w_rst), .start(w_start),
    .redirect_valid(w_redir), .redirect_address(w_redir_addr),
    .instruction_address(w_iaddr), .instruction(w_instr),
    .out_valid(w_ovalid), .out_ready(w_ready),
    .out_instruction(w_oinstr), .out_pc(w_opc),
    .busy(w_busy), .done(w_done), .instr_count(w_cnt)
  );

  logic [4:0] q[$];
  logic [4:0] wq[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ovalid && ready) begin
      logic [4:0] a;
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_word: got pc %0d expected none", opc);
      end else begin
        a = q.pop_front();
        if (opc !== a || oinstr !== {11'd0, a}) begin
          fails++;
          $display("FAIL stream_word: got pc %0d instr %h expected pc %0d instr %h",
                   opc, oinstr, a, {11'd0, a});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!w_rst && w_ovalid && w_ready) begin
      logic [4:0] a;
      checks++;
      if (wq.size() == 0) begin
        fails++;
        $display("FAIL wrap_unexpected: got pc %0d expected none", w_opc);
      end else begin
        a = wq.pop_front();
        if (w_opc !== a || w_oinstr !== {11'd0, a}) begin
          fails++;
          $display("FAIL wrap_word: got pc %0d instr %h expected pc %0d instr %h",
                   w_opc, w_oinstr, a, {11'd0, a});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [4:0] p);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ovalid && opc == p) return;
    end
    check("wait_pc_timeout", 32'(opc), 32'(p));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; redir = 1'b0; redir_addr = '0; ready = 1'b0;
    w_rst = 1'b1; w_start = 1'b0; w_redir = 1'b0;
    w_redir_addr = '0; w_ready = 1'b0;
    tick(); tick();
    rst = 1'b0; w_rst = 1'b0;
    repeat (5) tick();
    check("idle_valid", 32'(ovalid), 0);
    check("idle_nop", 32'(oinstr), 32'h000F);
    check("idle_addr", 32'(iaddr), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
    check("idle_count", 32'(cnt), 0);

    for (int a = 0; a < 7; a++) q.push_back(5'(a));
    start = 1'b1; ready = 1'b1;
    wait_pc(3);
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_instr", 32'(oinstr), 32'h0003);
      check("bp_addr", 32'(iaddr), 4);
    end
    check("bp_count", 32'(cnt), 3);
    ready = 1'b1;

    wait_pc(7);
    check("pre_redir_count", 32'(cnt), 7);
    redir = 1'b1; redir_addr = 5'd20; ready = 1'b0;
    tick();
    check("redir_flush", 32'(ovalid), 0);
    check("redir_addr", 32'(iaddr), 20);
    redir = 1'b0; ready = 1'b1;
    for (int a = 20; a < 32; a++) q.push_back(5'(a));

    for (int i = 0; i < 100 && !done; i++) tick();
    check("end_done", 32'(done), 1);
    check("end_busy", 32'(busy), 0);
    check("end_count", 32'(cnt), 19);
    repeat (3) tick();
    check("end_no_valid", 32'(ovalid), 0);
    check("end_pc_hold", 32'(iaddr), 31);

    q.push_back(5'd0); q.push_back(5'd1);
    redir = 1'b1; redir_addr = 5'd0;
    tick();
    redir = 1'b0;
    check("resume_busy", 32'(busy), 1);
    check("resume_done", 32'(done), 0);
    wait_pc(2);
    ready = 1'b0;

    redir = 1'b1; redir_addr = 5'd12;
    tick();
    redir = 1'b0;
    wait_pc(12);
    check("mid_count", 32'(cnt), 21);
    rst = 1'b1; start = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_addr", 32'(iaddr), 0);
    check("rst_valid", 32'(ovalid), 0);
    check("rst_count", 32'(cnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_nop", 32'(oinstr), 32'h000F);
    repeat (3) tick();
    check("rst_stays_idle", 32'(busy), 0);
    check("main_queue_empty", 32'(q.size()), 0);

    // Simultaneous start and redirect from IDLE, then wrap 31 -> 0
    wq.push_back(5'd29); wq.push_back(5'd30); wq.push_back(5'd31);
    wq.push_back(5'd0);  wq.push_back(5'd1);
    w_start = 1'b1; w_redir = 1'b1; w_redir_addr = 5'd29; w_ready = 1'b1;
    tick();
    w_redir = 1'b0;
    check("wrap_addr", 32'(w_iaddr), 29);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (w_ovalid && w_opc == 5'd2) break;
    end
    w_ready = 1'b0;
    check("wrap_reach", 32'(w_opc), 2);
    check("wrap_busy", 32'(w_busy), 1);
    check("wrap_done", 32'(w_done), 0);
    tick();
    check("wrap_queue_empty", 32'(wq.size()), 0);
    check("wrap_count", 32'(w_cnt), 5);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Program counter and fetch stage that sits directly upstream of program_memory. It drives instruction_address to program_memory and registers the returned instruction into a one-entry output buffer. The buffer feeds the decode/execute stage over a valid/ready handshake, with support for redirect (jump/branch), start/idle control and end-of-program detection.

Parameters:
BITS_FOR_INSTRUCTIONS, 5, width of the PC and instruction_address
INSTRUCTION_WIDTH, 16, instruction word width
NUMBER_OF_INSTRUCTIONS, 32, number of valid program addresses (0 .. N-1)
LAST_ADDRESS, NUMBER_OF_INSTRUCTIONS-1, address of the final program instruction
WRAP_AROUND, 0, 1 = PC wraps to 0 after LAST_ADDRESS and fetching continues; 0 = stop after LAST_ADDRESS

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  level; leaves IDLE and begins fetching
redirect_valid  input  1  one-cycle pulse; load PC from redirect_address and flush the buffer
redirect_address  input  BITS_FOR_INSTRUCTIONS  jump target
instruction_address  output  BITS_FOR_INSTRUCTIONS  to program_memory; equals PC register (combinational)
instruction  input  INSTRUCTION_WIDTH  from program_memory (combinational read of instruction_address)
out_valid  output  1  out_instruction/out_pc hold a valid fetched word
out_ready  input  1  consumer accepts the word this cycle
out_instruction  output  INSTRUCTION_WIDTH  registered instruction
out_pc  output  BITS_FOR_INSTRUCTIONS  address out_instruction was fetched from
busy  output  1  state is RUN
done  output  1  state is DONE and out_valid==0
instr_count  output  16  number of accepted handshakes (out_valid&&out_ready); saturates at 16'hFFFF

Behaviour:
- Reset (rst=1 at edge, overrides everything, including mid-fetch): PC=0, state=IDLE, out_valid=0, out_instruction={12'd0,4'b1111} (NOP), out_pc=0, instr_count=0, busy=0, done=0.
- States: IDLE, RUN, DONE.
- Define slot_free = !out_valid || out_ready.
- Define fetch = (state==RUN) && slot_free && !redirect_valid.
- On fetch: out_instruction<=instruction, out_pc<=PC, out_valid<=1.
- PC advance on fetch:
  - If PC==LAST_ADDRESS and WRAP_AROUND==0: PC holds, state->DONE.
  - If PC==LAST_ADDRESS and WRAP_AROUND==1: PC<=0.
  - Otherwise: PC<=PC+1, with modulo wrap to 0 if PC+1 >= NUMBER_OF_INSTRUCTIONS.
- Latency: a word at address A appears on out_instruction the cycle after instruction_address==A. Throughput is 1 word/cycle while out_ready=1.
- Backpressure: out_valid=1 && out_ready=0 → PC, out_instruction and out_pc hold stable; no fetch.
- Any cycle in which out_valid=1 && out_ready=1 and no fetch occurs: out_valid<=0.
- Redirect (any state, highest priority after rst):
  - PC<=redirect_address; if redirect_address >= NUMBER_OF_INSTRUCTIONS, PC<=0.
  - out_valid<=0: the buffered word is discarded, even if out_ready=1 that cycle. A simultaneous handshake still counts in instr_count.
  - State->RUN.
- IDLE: start=1 → RUN next cycle. The first fetch happens in the following cycle from the current PC.
- start is ignored in RUN and DONE.
- DONE: no fetch. out_valid drains via the handshake. done=1 once out_valid==0. Only redirect or rst leave DONE.
- instr_count increments on each out_valid&&out_ready and holds at 16'hFFFF.
- Simultaneous start and redirect in IDLE: redirect applies (PC loaded), state->RUN.

Test Plan:
- Reset/idle: bench memory model returns instruction={11'd0,addr}. rst pulse, start=0 for 5 cycles → out_valid=0, out_instruction=16'h000F, instruction_address=0, busy=0.
- Streaming: start=1, out_ready=1 → out_instruction 0x0000,0x0001,0x0002… on consecutive cycles; out_pc matches; instr_count=10 after 10 accepted words.
- Backpressure: at out_pc=3, hold out_ready=0 for 4 cycles → out_instruction=0x0003 and instruction_address=4 stable; on release, 0x0004 appears next cycle with no loss or duplication.
- Redirect: redirect_valid with redirect_address=20 while out_valid=1 (out_pc=7) → out_valid=0 next cycle, then out_instruction=0x0014, out_pc=20; word 7 is never handshaken if out_ready=0 that cycle.
- End/wrap: WRAP_AROUND=0, LAST_ADDRESS=31 → after out_pc=31 is accepted, done=1, busy=0, no further out_valid; redirect to 0 → RUN resumes at 0. With WRAP_AROUND=1, out_pc 31 is followed by 0.
- Reset mid-operation: rst during backpressure with out_pc=12 → next cycle PC=0, out_valid=0, instr_count=0, state IDLE.
